// File: rtl/fifo_unpack_reader_pkg.sv
// fifo_unpack_reader_pkg: shared FSM encodings and sizing helper for the FIFO unpack reader.
package fifo_unpack_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    function automatic int clog2(input int v);
        for (int r = 0; r < 32; r++)
            if ((1 << r) >= v) return r;
        return 32;
    endfunction

endpackage

// File: rtl/fifo_unpack_slicer.sv
// fifo_unpack_slicer: hold register plus registered output stage emitting a word LSB slice first.
module fifo_unpack_slicer
    import fifo_unpack_reader_pkg::*;
#(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [IN_WIDTH-1:0]  load_data,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    output logic                 out_last,
    output logic                 hold_valid,
    output logic                 last_slice,
    output logic                 hold_adv
);

    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int IDX_W = clog2(RATIO) > 1 ? clog2(RATIO) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    logic [RATIO-1:0][OUT_WIDTH-1:0] hold_data;
    logic [IDX_W-1:0]                sub_idx;
    logic                            out_adv;

    assign out_adv    = !out_valid || out_ready;
    assign hold_adv   = hold_valid && out_adv;
    assign last_slice = sub_idx == LAST_IDX;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_data  <= '0;
            hold_valid <= 1'b0;
            sub_idx    <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
        end else begin
            if (hold_adv) begin
                out_data  <= hold_data[sub_idx];
                out_valid <= 1'b1;
                out_last  <= last_slice;
            end else if (out_adv) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            // a load on the last-slice edge overrides the wrap, keeping the stream gapless
            if (load) begin
                hold_data  <= load_data;
                hold_valid <= 1'b1;
                sub_idx    <= '0;
            end else if (hold_adv) begin
                hold_valid <= !last_slice;
                sub_idx    <= last_slice ? '0 : sub_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_unpack_reader.sv
// fifo_unpack_reader: drains an async FIFO read port, unpacking each word into sub-words on a
// valid/ready stream with start-up priming, clean stop and underflow monitoring.
module fifo_unpack_reader
    import fifo_unpack_reader_pkg::*;
#(
    parameter int IN_WIDTH    = 32,
    parameter int OUT_WIDTH   = 8,
    parameter int COUNT_WIDTH = 5,
    parameter int PRIME_WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    output logic                   busy,
    input  logic [IN_WIDTH-1:0]    fifo_rd_data,
    input  logic                   fifo_empty,
    input  logic [COUNT_WIDTH-1:0] fifo_count,
    output logic                   fifo_rd_en,
    output logic [OUT_WIDTH-1:0]   out_data,
    output logic                   out_valid,
    output logic                   out_last,
    input  logic                   out_ready,
    output logic                   underflow,
    output logic [15:0]            underflow_count
);

    localparam int PRIME_MAX = 1 << (COUNT_WIDTH - 1);
    localparam int PRIME_CAP = PRIME_WORDS > PRIME_MAX ? PRIME_MAX : PRIME_WORDS;
    localparam logic [COUNT_WIDTH-1:0] PRIME_THR = COUNT_WIDTH'(PRIME_CAP);

    state_t state, state_nxt;
    logic   started;
    logic   hold_valid, last_slice, hold_adv;
    logic   primed, drain_done, under_cyc;

    assign primed     = fifo_count >= PRIME_THR;
    assign drain_done = !hold_valid && (!out_valid || out_ready);
    assign under_cyc  = state == RUN && started && out_ready && !out_valid;
    assign busy       = state != IDLE;
    assign fifo_rd_en = state == RUN && !fifo_empty && (!hold_valid || (hold_adv && last_slice));

    fifo_unpack_slicer #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) slicer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (fifo_rd_en),
        .load_data  (fifo_rd_data),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .hold_valid (hold_valid),
        .last_slice (last_slice),
        .hold_adv   (hold_adv)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  state_nxt = enable ? PRIME : IDLE;
            PRIME: state_nxt = !enable ? IDLE : (primed ? RUN : PRIME);
            RUN:   state_nxt = enable ? RUN : DRAIN;
            DRAIN: state_nxt = drain_done ? IDLE : DRAIN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // underflow is only meaningful once the consumer has seen real data in this run
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started         <= 1'b0;
            underflow       <= 1'b0;
            underflow_count <= '0;
        end else if (state == IDLE && enable) begin
            started         <= 1'b0;
            underflow       <= 1'b0;
            underflow_count <= '0;
        end else begin
            if (state == RUN && out_valid && out_ready) started <= 1'b1;
            if (under_cyc) begin
                underflow <= 1'b1;
                if (underflow_count != 16'hFFFF) underflow_count <= underflow_count + 16'd1;
            end
        end
    end

endmodule
